// File: rtl/game2_pkg.sv
// Shared direction and repeat-FSM encodings for the game2 input path.
// Pure declarations: no logic, no latency, no flow control.
package game2_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/move_cmd_fifo.sv
// Synchronous 1-bit FIFO; push visible at the head one cycle later, pop acts on the head.
// Push when full is dropped unless a pop happens the same cycle; pop when empty is ignored.
module move_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic                     push_dat,
    input  logic                     pop_vld,
    output logic                     head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mem_q [DEPTH];
    logic          mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_vld & ~empty;
        // a pop frees the slot the simultaneous push needs when full
        push_ok  = push_vld & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Turns left/right pulses (and, with MOVE_CMD_AUTO_REPEAT_EN, held buttons) into queued move
// commands; command visible on cmd_valid the cycle after its event, overflow sticks when full.
module move_cmd_scheduler
    import game2_pkg::*;
#(
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int CNT_W         = 24,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          system_clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          lbt,
    input  logic                          rbt,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic                          cmd_dir,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    logic left_prev_q,   left_prev_d;
    logic right_prev_q,  right_prev_d;
    logic pending_q,     pending_d;
    logic pending_dir_q, pending_dir_d;
    logic defer_l_q,     defer_l_d;
    logic defer_r_q,     defer_r_d;
    logic last_grant_q,  last_grant_d;
    logic overflow_q,    overflow_d;

    logic ev_l, ev_r;
    logic edge_push, edge_dir;
    logic push_vld, push_dat;
    logic pop_vld;
    logic fifo_full, fifo_empty, head_dat;

    always_comb begin
        left_prev_d   = left;
        right_prev_d  = right;
        ev_l          = (left & ~left_prev_q) | defer_l_q;
        ev_r          = (right & ~right_prev_q) | defer_r_q;
        pending_d     = 1'b0;
        pending_dir_d = pending_dir_q;
        defer_l_d     = 1'b0;
        defer_r_d     = 1'b0;
        last_grant_d  = last_grant_q;
        edge_push     = 1'b0;
        edge_dir      = DIR_LEFT;
        if (pending_q) begin
            // the loser of the last tie goes first; fresh edges wait one cycle
            edge_push = 1'b1;
            edge_dir  = pending_dir_q;
            defer_l_d = ev_l;
            defer_r_d = ev_r;
        end else if (ev_l && ev_r) begin
            edge_push     = 1'b1;
            edge_dir      = ~last_grant_q;
            last_grant_d  = ~last_grant_q;
            pending_d     = 1'b1;
            pending_dir_d = last_grant_q;
        end else if (ev_l) begin
            edge_push    = 1'b1;
            edge_dir     = DIR_LEFT;
            last_grant_d = DIR_LEFT;
        end else if (ev_r) begin
            edge_push    = 1'b1;
            edge_dir     = DIR_RIGHT;
            last_grant_d = DIR_RIGHT;
        end
    end

`ifdef MOVE_CMD_AUTO_REPEAT_EN
    rpt_state_e       state_q, state_d;
    logic             held_dir_q, held_dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             held_lvl;
    logic             rpt_push;

    always_comb begin
        state_d    = state_q;
        held_dir_d = held_dir_q;
        timer_d    = timer_q;
        rpt_push   = 1'b0;
        held_lvl   = (held_dir_q == DIR_RIGHT) ? rbt : lbt;
        if (edge_push) begin
            state_d    = RPT_HOLD;
            held_dir_d = edge_dir;
            timer_d    = '0;
        end else if (state_q != RPT_IDLE) begin
            if (!held_lvl) begin
                state_d = RPT_IDLE;
                timer_d = '0;
            end else if (state_q == RPT_HOLD && timer_q == CNT_W'(HOLD_DELAY - 1)) begin
                rpt_push = 1'b1;
                state_d  = RPT_REPEAT;
                timer_d  = '0;
            end else if (state_q == RPT_REPEAT && timer_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                rpt_push = 1'b1;
                timer_d  = '0;
            end else begin
                timer_d = timer_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q    <= RPT_IDLE;
            held_dir_q <= DIR_LEFT;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            held_dir_q <= held_dir_d;
            timer_q    <= timer_d;
        end
    end

    assign push_vld = edge_push | rpt_push;
    assign push_dat = edge_push ? edge_dir : held_dir_q;
`else
    logic [CNT_W-1:0] unused_cfg;
    assign unused_cfg = CNT_W'(HOLD_DELAY) ^ CNT_W'(REPEAT_PERIOD) ^ CNT_W'({lbt, rbt});

    assign push_vld = edge_push;
    assign push_dat = edge_dir;
`endif

    assign pop_vld = cmd_ready & ~fifo_empty;

    always_comb begin
        overflow_d = overflow_q | (push_vld & fifo_full & ~pop_vld);
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            left_prev_q   <= 1'b0;
            right_prev_q  <= 1'b0;
            pending_q     <= 1'b0;
            pending_dir_q <= DIR_LEFT;
            defer_l_q     <= 1'b0;
            defer_r_q     <= 1'b0;
            last_grant_q  <= DIR_RIGHT;
            overflow_q    <= 1'b0;
        end else begin
            left_prev_q   <= left_prev_d;
            right_prev_q  <= right_prev_d;
            pending_q     <= pending_d;
            pending_dir_q <= pending_dir_d;
            defer_l_q     <= defer_l_d;
            defer_r_q     <= defer_r_d;
            last_grant_q  <= last_grant_d;
            overflow_q    <= overflow_d;
        end
    end

    move_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (system_clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_valid = ~fifo_empty;
    assign cmd_dir   = head_dat;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed bench for move_cmd_scheduler with short hold/repeat timing.
module tb_move_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0, right = 1'b0, lbt = 1'b0, rbt = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, cmd_dir, overflow;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int log_cyc[$];
    logic log_dir[$];

    move_cmd_scheduler #(
        .HOLD_DELAY    (8),
        .REPEAT_PERIOD (4),
        .CNT_W         (24),
        .FIFO_DEPTH    (4)
    ) dut (
        .system_clk (clk),
        .rst        (rst),
        .left       (left),
        .right      (right),
        .lbt        (lbt),
        .rbt        (rbt),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            log_cyc.push_back(cyc);
            log_dir.push_back(cmd_dir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        left = 1'b0; right = 1'b0; lbt = 1'b0; rbt = 1'b0; cmd_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        log_cyc.delete();
        log_dir.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_valid, cmd_dir, fifo_count, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b dir=%b count=%0d ovf=%b, want all 0",
                     cmd_valid, cmd_dir, fifo_count, overflow);
        end
    endtask

    task automatic test_single_left();
        int e0;
        do_reset();
        cmd_ready = 1'b1;
        left = 1'b1; lbt = 1'b1;
        e0 = cyc;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_dir !== 1'b0) begin
            errors++;
            $display("FAIL single_first: got valid=%b dir=%b, want valid=1 dir=0", cmd_valid, cmd_dir);
        end
        tick();
        left = 1'b0; lbt = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_second: got valid=%b, want 0", cmd_valid);
        end
        repeat (15) tick();
        checks++;
        if (log_cyc.size() != 1 || log_cyc[0] != e0 + 1 || log_dir[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got %0d cmds (first at +%0d), want 1 left cmd at +1",
                     log_cyc.size(), (log_cyc.size() > 0) ? log_cyc[0] - e0 : -1);
        end
    endtask

    task automatic test_tie();
        do_reset();
        left = 1'b1; right = 1'b1;
        tick();
        left = 1'b0; right = 1'b0;
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL tie1_count_a: got %0d, want 1", fifo_count);
        end
        tick();
        checks++;
        if (fifo_count !== 3'd2 || cmd_dir !== 1'b0) begin
            errors++;
            $display("FAIL tie1_head: got count=%0d dir=%b, want count=2 dir=0", fifo_count, cmd_dir);
        end
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_dir !== 1'b1) begin
            errors++;
            $display("FAIL tie1_second: got valid=%b dir=%b, want valid=1 dir=1", cmd_valid, cmd_dir);
        end
        tick();
        cmd_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL tie1_drain: got count=%0d, want 0", fifo_count);
        end
        left = 1'b1; right = 1'b1;
        tick();
        left = 1'b0; right = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 3'd2 || cmd_dir !== 1'b1) begin
            errors++;
            $display("FAIL tie2_head: got count=%0d dir=%b, want count=2 dir=1", fifo_count, cmd_dir);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_dir !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL tie2_second: got valid=%b dir=%b count=%0d, want valid=1 dir=0 count=1",
                     cmd_valid, cmd_dir, fifo_count);
        end
    endtask

    task automatic test_hold_repeat();
        int e0;
        int exp_off[$];
`ifdef MOVE_CMD_AUTO_REPEAT_EN
        exp_off = '{1, 9, 13, 17, 21};
`else
        exp_off = '{1};
`endif
        do_reset();
        cmd_ready = 1'b1;
        right = 1'b1; rbt = 1'b1;
        e0 = cyc;
        tick();
        tick();
        right = 1'b0;
        repeat (19) tick();
        rbt = 1'b0;
        repeat (20) tick();
        checks++;
        if (log_cyc.size() != exp_off.size()) begin
            errors++;
            $display("FAIL hold_count: got %0d cmds, want %0d", log_cyc.size(), exp_off.size());
        end
        for (int i = 0; i < log_cyc.size() && i < exp_off.size(); i++) begin
            checks++;
            if (log_cyc[i] - e0 != exp_off[i] || log_dir[i] !== 1'b1) begin
                errors++;
                $display("FAIL hold_cmd%0d: got offset=%0d dir=%b, want offset=%0d dir=1",
                         i, log_cyc[i] - e0, log_dir[i], exp_off[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (6) begin
            left = 1'b1;
            tick();
            tick();
            left = 1'b0;
            tick();
            tick();
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill: got count=%0d ovf=%b, want count=4 ovf=1", fifo_count, overflow);
        end
        cmd_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (log_cyc.size() != 4 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain: got cmds=%0d count=%0d ovf=%b, want cmds=4 count=0 ovf=1",
                     log_cyc.size(), fifo_count, overflow);
        end
        for (int i = 0; i < log_dir.size(); i++) begin
            checks++;
            if (log_dir[i] !== 1'b0) begin
                errors++;
                $display("FAIL ovf_dir%0d: got %b, want 0", i, log_dir[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        repeat (4) begin
            left = 1'b1;
            tick();
            left = 1'b0;
            tick();
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_fill: got count=%0d ovf=%b, want count=4 ovf=0", fifo_count, overflow);
        end
        left = 1'b1; cmd_ready = 1'b1;
        tick();
        left = 1'b0; cmd_ready = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || log_cyc.size() != 1) begin
            errors++;
            $display("FAIL full_pushpop: got count=%0d ovf=%b pops=%0d, want count=4 ovf=0 pops=1",
                     fifo_count, overflow, log_cyc.size());
        end
        tick();
        left = 1'b1;
        tick();
        left = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: got count=%0d ovf=%b, want count=4 ovf=1", fifo_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int max_cnt;
        logic [2:0] exp_q;
`ifdef MOVE_CMD_AUTO_REPEAT_EN
        exp_q = 3'd3;
`else
        exp_q = 3'd1;
`endif
        do_reset();
        left = 1'b1; lbt = 1'b1;
        tick();
        tick();
        left = 1'b0;
        repeat (11) tick();
        checks++;
        if (fifo_count !== exp_q) begin
            errors++;
            $display("FAIL mid_queued: got count=%0d, want %0d", fifo_count, exp_q);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b count=%0d ovf=%b, want all 0",
                     cmd_valid, fifo_count, overflow);
        end
        max_cnt = 0;
        repeat (20) begin
            tick();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        checks++;
        if (max_cnt != 0) begin
            errors++;
            $display("FAIL mid_no_repeat: got peak count=%0d, want 0", max_cnt);
        end
        lbt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_left();
        test_tie();
        test_hold_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
